// File: rtl/det_event_counter.sv
// Windowed counter of 101-detector matches with a valid/ready report port.
// Optional build macro EVT_IRQ_EN adds the in-window threshold interrupt.
module det_event_counter #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned WIN_LEN = 16,
   parameter int unsigned THRESH  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             det_in,
   input  logic             clr,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_count,
   output logic             rpt_drop,
   output logic             irq
);

   localparam int unsigned      WIN_W    = $clog2(WIN_LEN);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   if (CNT_W < 2 || WIN_LEN < 2 || THRESH < 1 || THRESH >= (1 << CNT_W)) begin : g_bad_param
      $error("det_event_counter: illegal parameter combination");
   end

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   logic             r_det_q;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_evt_cnt;
   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_rpt_valid;
   logic [CNT_W-1:0] r_rpt_count;
   logic             r_rpt_drop;

   logic             w_evt;
   logic             w_win_end;
   logic [CNT_W-1:0] w_snap;
   logic             w_load;
   logic             w_drop_set;

   // A run of high det_in yields a single event on its first cycle
   assign w_evt     = det_in & ~r_det_q;
   assign w_win_end = (r_win_cnt == WIN_LAST);
   assign w_snap    = (w_evt && (r_evt_cnt != CNT_MAX)) ? r_evt_cnt + CNT_W'(1) : r_evt_cnt;

   // Report FSM next-state and load/drop decisions
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_drop_set  = 1'b0;
      if (clr) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win_end) begin
                  w_state_nxt = S_HOLD;
                  w_load      = 1'b1;
               end
            end
            S_HOLD: begin
               if (w_win_end) begin
                  if (rpt_ready) begin
                     w_load = 1'b1;
                  end else begin
                     w_drop_set = 1'b1;
                  end
               end else if (rpt_ready) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rpt_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rpt_valid <= (w_state_nxt == S_HOLD);
      end
   end

   // det_q keeps tracking through clr so a held-high input is not recounted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_det_q     <= 1'b0;
         r_win_cnt   <= '0;
         r_evt_cnt   <= '0;
         r_rpt_count <= '0;
         r_rpt_drop  <= 1'b0;
      end else begin
         r_det_q <= det_in;
         if (clr) begin
            r_win_cnt  <= '0;
            r_evt_cnt  <= '0;
            r_rpt_drop <= 1'b0;
         end else begin
            if (w_win_end) begin
               r_win_cnt <= '0;
               r_evt_cnt <= '0;
            end else begin
               r_win_cnt <= r_win_cnt + WIN_W'(1);
               r_evt_cnt <= w_snap;
            end
            if (w_load) begin
               r_rpt_count <= w_snap;
            end
            if (w_drop_set) begin
               r_rpt_drop <= 1'b1;
            end
         end
      end
   end

   assign rpt_valid = r_rpt_valid;
   assign rpt_count = r_rpt_count;
   assign rpt_drop  = r_rpt_drop;

`ifdef EVT_IRQ_EN
   localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESH - 1);

   logic r_irq;

   // The count rises monotonically inside a window, so the crossing happens at most once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= ~clr & w_evt & (r_evt_cnt == THR_M1);
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_det_event_counter.sv
// Bench for det_event_counter: default instance plus a CNT_W=2 instance, both
// compared every cycle against a window/event-count reference model.
module tb_det_event_counter;

   localparam int unsigned WIN = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       det_in = 1'b0;
   logic       clr = 1'b0;
   logic       rpt_ready = 1'b0;

   logic       rpt_valid, rpt_drop, irq;
   logic [7:0] rpt_count;
   logic       rpt_valid_s, rpt_drop_s, irq_s;
   logic [1:0] rpt_count_s;

   int n_chk = 0;
   int n_fail = 0;

   det_event_counter #(.CNT_W(8), .WIN_LEN(WIN), .THRESH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .det_in(det_in), .clr(clr),
      .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_count(rpt_count),
      .rpt_drop(rpt_drop), .irq(irq)
   );

   det_event_counter #(.CNT_W(2), .WIN_LEN(WIN), .THRESH(3)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .det_in(det_in), .clr(clr),
      .rpt_valid(rpt_valid_s), .rpt_ready(rpt_ready), .rpt_count(rpt_count_s),
      .rpt_drop(rpt_drop_s), .irq(irq_s)
   );

   always #5 clk = ~clk;

   // Reference model: window position, raw event tally, one-deep report slot
   bit m_prev, m_have, m_drop, m_irq, m_irq_s;
   int m_pos, m_ev, m_rv, m_rv_s;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_prev = 0; m_have = 0; m_drop = 0; m_irq = 0; m_irq_s = 0;
      m_pos = 0; m_ev = 0; m_rv = 0; m_rv_s = 0;
   endtask

   task automatic model_tick(input bit d, input bit c, input bit r);
      bit e;
      int total;
      e = d && !m_prev;
      m_prev = d;
      m_irq = 0;
      m_irq_s = 0;
      if (c) begin
         m_pos = 0; m_ev = 0; m_have = 0; m_drop = 0;
      end else begin
`ifdef EVT_IRQ_EN
         m_irq   = e && (m_ev == 3);
         m_irq_s = e && (m_ev == 2);
`endif
         total = m_ev + int'(e);
         if (m_pos == WIN - 1) begin
            if (!m_have || r) begin
               m_have = 1;
               m_rv   = min_i(total, 255);
               m_rv_s = min_i(total, 3);
            end else begin
               m_drop = 1;
            end
            m_pos = 0;
            m_ev  = 0;
         end else begin
            if (m_have && r) m_have = 0;
            m_pos++;
            m_ev = total;
         end
      end
   endtask

   task automatic compare_all();
      check("valid",   int'(rpt_valid),   int'(m_have));
      check("count",   int'(rpt_count),   m_rv);
      check("drop",    int'(rpt_drop),    int'(m_drop));
      check("irq",     int'(irq),         int'(m_irq));
      check("valid_s", int'(rpt_valid_s), int'(m_have));
      check("count_s", int'(rpt_count_s), m_rv_s);
      check("drop_s",  int'(rpt_drop_s),  int'(m_drop));
      check("irq_s",   int'(irq_s),       int'(m_irq_s));
   endtask

   // Called at a negedge: drive, clock once, then compare at the next negedge
   task automatic step(input bit d, input bit c, input bit r);
      det_in = d; clr = c; rpt_ready = r;
      @(posedge clk);
      model_tick(d, c, r);
      @(negedge clk);
      compare_all();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("rst_valid", int'(rpt_valid), 0);
      check("rst_count", int'(rpt_count), 0);
      check("rst_drop",  int'(rpt_drop),  0);
      check("rst_irq",   int'(irq),       0);
      check("rst_cnt_s", int'(rpt_count_s), 0);
      model_reset();
      det_in = 1'b0; clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit d;
      bit c;
      bit r;
      #2;
      apply_reset();

      // Quiet window: empty report one cycle after cycle 15
      for (int i = 0; i < WIN; i++) step(1'b0, 1'b0, 1'b1);
      check("t1_valid", int'(rpt_valid), 1);
      check("t1_count", int'(rpt_count), 0);
      check("t1_drop",  int'(rpt_drop),  0);

      // Three single pulses plus a 5-cycle run
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < WIN; i++) begin
         d = (i == 1 || i == 3 || i == 5 || (i >= 7 && i <= 11));
         step(d, 1'b0, 1'b1);
      end
      check("t2_count", int'(rpt_count), 4);
      check("t2_cnt_s", int'(rpt_count_s), 3);

      // Rise on the window-end cycle belongs to the ending window
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < WIN; i++) step(i == WIN - 1, 1'b0, 1'b1);
      check("t3_count", int'(rpt_count), 1);
      for (int i = 0; i < WIN; i++) step(1'b0, 1'b0, 1'b1);
      check("t3_next", int'(rpt_count), 0);

      // Stalled reader: first report held, second discarded
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) step((i % WIN == 3) || (i % WIN == 9), 1'b0, 1'b0);
      check("t4_count", int'(rpt_count), 2);
      check("t4_valid", int'(rpt_valid), 1);
      check("t4_drop",  int'(rpt_drop),  1);
      step(1'b0, 1'b0, 1'b1);
      check("t4_release", int'(rpt_valid), 0);

      // Saturation of the 2-bit counter with 6 events
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < WIN; i++) step((i < 12) && (i % 2 == 0), 1'b0, 1'b1);
      check("t5_count", int'(rpt_count), 6);
      check("t5_cnt_s", int'(rpt_count_s), 3);

      // clr in HOLD with det_in held high
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2 * WIN; i++) step(1'b0, 1'b0, 1'b0);
      check("t6_drop_pre", int'(rpt_drop), 1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("t6_valid", int'(rpt_valid), 0);
      check("t6_drop",  int'(rpt_drop),  0);
      for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b1);
      check("t6_count", int'(rpt_count), 0);
      check("t6_rpt",   int'(rpt_valid), 1);

      // Randomised traffic with a mid-run async reset
      d = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) d = ~d;
         c = ($urandom_range(0, 59) == 0);
         r = ($urandom_range(0, 3) != 0) && !((i % 100) >= 60 && (i % 100) < 90);
         if (i == 211) apply_reset();
         step(d, c, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
